// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule that fills a round-key register file, one round key per clock.
// Latency is ROUNDS+1 edges from start to done. start is ignored while busy; rd_key returns a key one cycle after rd_idx.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[a];
endmodule

module aes_key_expand #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);
    localparam logic [3:0] LAST = 4'(ROUNDS);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt;
    logic [127:0]   w;
    logic [127:0]   rk [0:ROUNDS];
    logic [31:0]    rot, sub, t;
    logic [31:0]    nw0, nw1, nw2, nw3;
    logic [7:0]     rcon;
    logic           accept, last;

    always_comb begin
        rcon = 8'h00;
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {w[23:0], w[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .s(sub[8*g +: 8]));
    end

    assign t   = sub ^ {rcon, 24'h0};
    assign nw0 = w[127:96] ^ t;
    assign nw1 = w[95:64]  ^ nw0;
    assign nw2 = w[63:32]  ^ nw1;
    assign nw3 = w[31:0]   ^ nw2;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt        <= '0;
            w          <= '0;
            rd_key     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= ROUNDS; i++) rk[i] <= '0;
        end else begin
            state_q <= state_d;
            rd_key  <= (rd_idx <= LAST) ? rk[rd_idx] : '0;
            if (accept) begin
                rk[0]      <= key_in;
                w          <= key_in;
                cnt        <= 4'd1;
                busy       <= 1'b1;
                keys_valid <= 1'b0;
                done       <= 1'b0;
            end else if (state_q == EXPAND) begin
                rk[cnt] <= {nw0, nw1, nw2, nw3};
                w       <= {nw0, nw1, nw2, nw3};
                cnt     <= cnt + 4'd1;
                if (last) begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                end
            end else begin
                done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: reference key schedule built from GF(2^8) arithmetic,
// table-driven read-back through a scoreboard queue, plus handshake, abort and back-to-back sequences.
module tb_aes_key_expand;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
    logic         busy, done, keys_valid;

    int n_checks = 0;
    int n_pass = 0;
    logic [127:0] sb_q[$];

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t tbl1[16];
    rd_vec_t tbl2[16];

    aes_key_expand #(.ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rd_idx(rd_idx),
        .rd_key(rd_key), .busy(busy), .done(done), .keys_valid(keys_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv, r, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        r = inv; s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int n);
        logic [127:0] w;
        logic [31:0]  t, w0, w1, w2, w3;
        logic [7:0]   rc;
        w = key; rc = 8'h01;
        for (int r = 1; r <= n; r++) begin
            t  = {sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0]), sbox_ref(w[31:24])} ^ {rc, 24'h0};
            w0 = w[127:96] ^ t;
            w1 = w[95:64] ^ w0;
            w2 = w[63:32] ^ w1;
            w3 = w[31:0] ^ w2;
            w  = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic read_check(input logic [3:0] idx, input logic [127:0] exp, input string name);
        rd_idx = idx;
        sb_q.push_back(exp);
        tick();
        check(name, rd_key, sb_q.pop_front());
    endtask

    task automatic run_reads(input bit second);
        rd_vec_t v;
        for (int k = 0; k < 16; k++) begin
            v = second ? tbl2[k] : tbl1[k];
            read_check(v.idx, v.exp, $sformatf("%s_rk%0d", second ? "k2" : "k1", v.idx));
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        if (done !== 1'b1) check("done_timeout", {127'b0, done}, 128'd1);
    endtask

    // Starts an expansion and samples the handshake for 15 cycles after the accepting edge.
    task automatic run_profile(input logic [127:0] key, input int glitch_at, input logic [127:0] glitch_key,
                               output int busy_cnt, output int done_cnt, output int done_at, output int kv_at);
        busy_cnt = 0; done_cnt = 0; done_at = -1; kv_at = -1;
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) tick();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (keys_valid === 1'b1 && kv_at < 0) kv_at = i;
            if (i == glitch_at) begin
                key_in = glitch_key;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int bc, dc, da, ka, cyc, low, dseen;

        for (int k = 0; k < 16; k++) begin
            if (k <= 10) begin
                tbl1[k].idx = 4'(10 - k); tbl1[k].exp = model_rk(K1, 10 - k);
                tbl2[k].idx = 4'(10 - k); tbl2[k].exp = model_rk(K2, 10 - k);
            end else begin
                tbl1[k].idx = 4'(k); tbl1[k].exp = '0;
                tbl2[k].idx = 4'(k); tbl2[k].exp = '0;
            end
        end

        // Reset state
        tick();
        tick();
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_done", {127'b0, done}, 128'd0);
        check("rst_keys_valid", {127'b0, keys_valid}, 128'd0);
        check("rst_rd_key", rd_key, 128'd0);
        rst = 1'b0;
        tick();

        // Single expansion: handshake timing and round keys
        run_profile(K1, -1, '0, bc, dc, da, ka);
        check("t1_busy_cycles", 128'(bc), 128'd10);
        check("t1_done_cycles", 128'(dc), 128'd1);
        check("t1_done_at", 128'(da), 128'd10);
        check("t1_kv_at", 128'(ka), 128'd10);
        run_reads(1'b0);
        read_check(4'd0, K1, "t1_rk0_lit");
        read_check(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "t1_rk1_lit");
        read_check(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "t1_rk10_lit");
        check("t1_kv_idle", {127'b0, keys_valid}, 128'd1);

        // start and key change during busy are ignored
        run_profile(K1, 3, K2, bc, dc, da, ka);
        check("t3_busy_cycles", 128'(bc), 128'd10);
        check("t3_done_at", 128'(da), 128'd10);
        check("t3_done_cycles", 128'(dc), 128'd1);
        run_reads(1'b0);

        // Asynchronous reset in the middle of an expansion
        rd_idx = 4'd0;
        key_in = K2;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t4_pre_rd_key", rd_key, K2);
        #3;
        rst = 1'b1;
        #1;
        check("t4_abort_busy", {127'b0, busy}, 128'd0);
        check("t4_abort_done", {127'b0, done}, 128'd0);
        check("t4_abort_kv", {127'b0, keys_valid}, 128'd0);
        check("t4_abort_rd_key", rd_key, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dseen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dseen++;
        end
        check("t4_no_done", 128'(dseen), 128'd0);
        read_check(4'd10, 128'd0, "t4_rk10_cleared");
        key_in = K1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(cyc);
        check("t4_restart_latency", 128'(cyc), 128'd10);
        check("t4_restart_kv", {127'b0, keys_valid}, 128'd1);

        // Back-to-back start in the done cycle
        key_in = K2;
        start  = 1'b1;
        rd_idx = 4'd10;
        tick();
        start  = 1'b0;
        check("t6_rk10_old_kept", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        low = 0;
        for (int j = 0; j < 20; j++) begin
            if (keys_valid !== 1'b0) break;
            low++;
            tick();
        end
        check("t6_kv_low_cycles", 128'(low), 128'd10);
        read_check(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "t6_rk10_lit");
        run_reads(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
